// File: rtl/aes_mix_columns_iter_if.sv
// aes_mix_columns_iter_if: valid/ready bundle between ShiftRows, the MixColumns stage and AddRoundKey
//   inValid/inReady/inData/inBypass : upstream state handshake (inBypass = final round, no mixing)
//   outValid/outReady/outData       : downstream result handshake
//   busy                            : stage holds a state (RUN or DONE)
interface aes_mix_columns_iter_if;
   logic         inValid;
   logic         inReady;
   logic [127:0] inData;
   logic         inBypass;
   logic         outValid;
   logic         outReady;
   logic [127:0] outData;
   logic         busy;
   modport master (output inValid, inData, inBypass, outReady, input inReady, outValid, outData, busy);
   modport slave  (input inValid, inData, inBypass, outReady, output inReady, outValid, outData, busy);
endinterface

// File: rtl/aes_mix_columns_iter.sv
// aes_mix_columns_iter: iterative AES (Inv)MixColumns, COLS_PER_CYCLE columns per clock
//   clk  : clock, rising edge
//   rstN : asynchronous active-low reset
//   bus  : slave side of aes_mix_columns_iter_if (in/out handshakes, data, bypass, busy)
module aes_mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1,
   parameter bit DECRYPT        = 1'b0
) (
   input logic                   clk,
   input logic                   rstN,
   aes_mix_columns_iter_if.slave bus
);
   localparam int N  = 4 / COLS_PER_CYCLE;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [127:0]    data_q, data_d;
   logic            bypass_q, bypass_d;
   logic [1:0]      col;
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   // Constant multiples built from the doubling chain: 09=8+1, 0B=8+2+1, 0D=8+4+1, 0E=8+4+2.
   function automatic logic [31:0] mix(input logic [31:0] c);
      logic [7:0]  s [4];
      logic [7:0]  x2 [4];
      logic [7:0]  x4 [4];
      logic [7:0]  x8 [4];
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         s[i]  = c[31-8*i -: 8];
         x2[i] = xt(s[i]);
         x4[i] = xt(x2[i]);
         x8[i] = xt(x4[i]);
      end
      for (int i = 0; i < 4; i++) begin
         r[31-8*i -: 8] = DECRYPT ?
            (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ s[(i+1)%4]) ^
            (x8[(i+2)%4] ^ x4[(i+2)%4] ^ s[(i+2)%4]) ^ (x8[(i+3)%4] ^ s[(i+3)%4]) :
            x2[i] ^ x2[(i+1)%4] ^ s[(i+1)%4] ^ s[(i+2)%4] ^ s[(i+3)%4];
      end
      return r;
   endfunction
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         bypass_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         bypass_q <= bypass_d;
      end
   end
   // Each column is read from data_q and written back to its own slot exactly once,
   // so a group never sees another group's partially mixed result.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      bypass_d = bypass_q;
      col      = '0;
      case (state_q)
         IDLE: if (bus.inValid) begin
            data_d   = bus.inData;
            bypass_d = bus.inBypass;
            cnt_d    = '0;
            state_d  = bus.inBypass ? DONE : RUN;
         end
         RUN: begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
               col = 2'(32'(cnt_q) * COLS_PER_CYCLE + j);
               if (!bypass_q) data_d[127-32*int'(col) -: 32] = mix(data_q[127-32*int'(col) -: 32]);
            end
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(N - 1) ? DONE : RUN;
         end
         DONE: state_d = bus.outReady ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   assign bus.inReady  = state_q == IDLE;
   assign bus.outValid = state_q == DONE;
   assign bus.busy     = state_q != IDLE;
   assign bus.outData  = data_q;
endmodule
